// File: rtl/string_comparator_pkg.sv
// Shared constants, types and byte-compare helper for the string comparator.
// STRING_COMPARATOR_NOCASE_EN selects ASCII case-insensitive letter compare.
package string_comparator_pkg;

  localparam int MAX_STRLEN  = 17;
  localparam int WORD_BYTES  = 4;
  localparam int WIN_WORDS   = 5;
  localparam int PIPE_STAGES = 6;
  localparam int WIN_BYTES   = WIN_WORDS * WORD_BYTES;

  typedef logic [7:0]                      byte_t;
  typedef logic [0:MAX_STRLEN-1][7:0]      flag_str_t;
  typedef logic [0:WIN_BYTES-1][7:0]       win_t;

`ifdef STRING_COMPARATOR_NOCASE_EN
  function automatic logic is_alpha(input byte_t a);
    byte_t lower;
    lower = a | 8'h20;
    return (lower >= 8'h61) && (lower <= 8'h7a);
  endfunction
`endif

  function automatic logic byte_eq(input byte_t a, input byte_t b);
    logic eq;
    eq = (a == b);
`ifdef STRING_COMPARATOR_NOCASE_EN
    // Letters only: '@' and '`' differ in bit 5 too but must stay distinct.
    if (is_alpha(a) && is_alpha(b)) eq = ((a | 8'h20) == (b | 8'h20));
`endif
    return eq;
  endfunction

endpackage

// File: rtl/strcmp_window_match.sv
// Combinational matcher: checks whether the target string ends at each of the
// four byte positions of the newest word in the 20-byte window.
module strcmp_window_match
  import string_comparator_pkg::*;
(
  input  win_t                  win,
  input  flag_str_t             flagged_string,
  input  logic [4:0]            strlen,
  output logic [WORD_BYTES-1:0] hit
);

  localparam int END_BASE = WIN_BYTES - WORD_BYTES;

  logic                  len_ok;
  logic [WORD_BYTES-1:0] eq;

  assign len_ok = (strlen != 5'd0) && (strlen <= 5'(MAX_STRLEN));

  always_comb begin
    eq = '1;
    for (int p = 0; p < WORD_BYTES; p++) begin
      // Walk backwards from the candidate end byte against the target tail.
      for (int i = 0; i < MAX_STRLEN; i++) begin
        if ((5'(i) < strlen) &&
            !byte_eq(win[END_BASE + p - i], flagged_string[MAX_STRLEN - 1 - i])) begin
          eq[p] = 1'b0;
        end
      end
    end
    hit = len_ok ? eq : '0;
  end

endmodule

// File: rtl/string_comparator.sv
// Six-stage word pipeline with a sticky match flag for a target string seen
// anywhere in the stream. Optional macro: STRING_COMPARATOR_NOCASE_EN.
module string_comparator
  import string_comparator_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  flag_str_t   flagged_string,
  input  logic [4:0]  strlen,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        match
);

  logic [PIPE_STAGES-1:0][31:0] pipe_q, pipe_d;
  logic                         match_q, match_d;
  win_t                         win;
  logic [WORD_BYTES-1:0]        hit_vec;

  // pipe_q[0] is stage 1 (newest word); the window is stages 1..5, oldest first.
  always_comb begin
    win = '0;
    for (int w = 0; w < WIN_WORDS; w++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        win[w*WORD_BYTES + b] = pipe_q[WIN_WORDS-1-w][8*(WORD_BYTES-1-b) +: 8];
      end
    end
  end

  strcmp_window_match u_match (
    .win            (win),
    .flagged_string (flagged_string),
    .strlen         (strlen),
    .hit            (hit_vec)
  );

  always_comb begin
    pipe_d  = {pipe_q[PIPE_STAGES-2:0], data_in};
    match_d = clear ? 1'b0 : (match_q | (|hit_vec));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pipe_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      match_q <= match_d;
    end
  end

  assign data_out = pipe_q[PIPE_STAGES-1];
  assign match    = match_q;

endmodule

// File: tb/tb_string_comparator.sv
// Directed bench for string_comparator: pipeline replay, sticky match,
// clear priority, length bounds and mid-stream reset.
module tb_string_comparator;

  localparam logic [31:0] SP = 32'h20202020;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              clear;
  logic [0:16][7:0]  flagged_string;
  logic [4:0]        strlen;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              match;

  int tests = 0;
  int fails = 0;

  logic [31:0] g_seq [0:3][0:4];
  logic [31:0] hist [$];

  string_comparator dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .clear          (clear),
    .flagged_string (flagged_string),
    .strlen         (strlen),
    .data_in        (data_in),
    .data_out       (data_out),
    .match          (match)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [31:0] w);
    data_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_clear();
    repeat (6) step(SP);
    clear = 1'b1;
    step(SP);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #1;
    n_rst = 1'b0;
    #3;
    tests++;
    if (data_out !== 32'h0) begin
      fails++; $display("FAIL reset data_out: got %h exp 00000000", data_out);
    end
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL reset match: got %b exp 0", match);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_google();
    logic [31:0] w;
    flagged_string = 136'("www.google.com");
    strlen = 5'd14;
    for (int off = 0; off < 4; off++) begin
      flush_clear();
      tests++;
      if (match !== 1'b0) begin
        fails++; $display("FAIL google off%0d pre-clear match: got %b exp 0", off, match);
      end
      hist.delete();
      for (int j = 0; j < 10; j++) begin
        w = (j < 5) ? g_seq[off][j] : SP;
        step(w);
        hist.push_back(w);
        if (j <= 3) begin
          tests++;
          if (match !== 1'b0) begin
            fails++; $display("FAIL google off%0d j%0d early match: got %b exp 0", off, j, match);
          end
        end
        if (j >= 5) begin
          tests++;
          if (match !== 1'b1) begin
            fails++; $display("FAIL google off%0d j%0d match: got %b exp 1", off, j, match);
          end
          tests++;
          if (data_out !== hist[hist.size()-6]) begin
            fails++; $display("FAIL google off%0d j%0d data_out: got %h exp %h",
                              off, j, data_out, hist[hist.size()-6]);
          end
        end
      end
    end
  endtask

  task automatic test_abc();
    logic [31:0] abc_w [0:1];
    abc_w[0] = "abc ";
    abc_w[1] = " abc";
    flagged_string = 136'("abc");
    strlen = 5'd3;
    for (int v = 0; v < 2; v++) begin
      for (int p = 0; p < 5; p++) begin
        flush_clear();
        for (int j = 0; j < 7; j++) step((j == p) ? abc_w[v] : SP);
        tests++;
        if (match !== 1'b1) begin
          fails++; $display("FAIL abc v%0d pos%0d match: got %b exp 1", v, p, match);
        end
      end
    end
    flush_clear();
    step("  ab");
    step("c   ");
    step(SP);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL abc boundary match: got %b exp 1", match);
    end
  endtask

  task automatic test_len17();
    flagged_string = 136'("www.linkedin.com/");
    strlen = 5'd17;
    flush_clear();
    step("www."); step("link"); step("edin"); step(".com"); step("/   ");
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL len17 early match: got %b exp 0", match);
    end
    step(SP);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL len17 match: got %b exp 1", match);
    end
    flagged_string = '1;
    flush_clear();
    repeat (6) step(32'hffffffff);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL len17 ones match: got %b exp 1", match);
    end
  endtask

  task automatic test_no_match();
    flagged_string = 136'("www.google.com");
    strlen = 5'd14;
    flush_clear();
    hist.delete();
    for (int j = 0; j < 10; j++) begin
      case (j)
        0: data_in = "www.";
        1: data_in = "goog";
        2: data_in = "book";
        3: data_in = ".com";
        default: data_in = SP;
      endcase
      hist.push_back(data_in);
      step(data_in);
      tests++;
      if (match !== 1'b0) begin
        fails++; $display("FAIL nomatch j%0d match: got %b exp 0", j, match);
      end
      if (j >= 5) begin
        tests++;
        if (data_out !== hist[j-5]) begin
          fails++; $display("FAIL nomatch j%0d data_out: got %h exp %h", j, data_out, hist[j-5]);
        end
      end
    end
  endtask

  task automatic test_bounds();
    logic [4:0] lens [0:3];
    logic       exp_m;
    lens[0] = 5'd0; lens[1] = 5'd18; lens[2] = 5'd31; lens[3] = 5'd17;
    flagged_string = '0;
    for (int k = 0; k < 4; k++) begin
      strlen = lens[k];
      exp_m = (k == 3);
      flush_clear();
      repeat (6) step(32'h0);
      tests++;
      if (match !== exp_m) begin
        fails++; $display("FAIL bounds strlen%0d match: got %b exp %b", lens[k], match, exp_m);
      end
    end
  endtask

  task automatic test_clear();
    flagged_string = '0;
    strlen = 5'd5;
    flush_clear();
    repeat (3) step(32'h0);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL clear setup match: got %b exp 1", match);
    end
    clear = 1'b1;
    step(32'h0);
    clear = 1'b0;
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL clear vs hit match: got %b exp 0", match);
    end
    step(32'h0);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL clear rehit match: got %b exp 1", match);
    end
    step(SP); step(SP);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL clear sticky match: got %b exp 1", match);
    end
    clear = 1'b1;
    step(SP);
    clear = 1'b0;
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL clear pulse match: got %b exp 0", match);
    end
    step(SP);
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL clear hold match: got %b exp 0", match);
    end
    flagged_string = 136'("abc");
    strlen = 5'd3;
    flush_clear();
    step("   a");
    clear = 1'b1;
    step("bc  ");
    clear = 1'b0;
    step(SP);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL clear keeps window match: got %b exp 1", match);
    end
    strlen = 5'd0;
    flagged_string = 136'("zzz");
    step(SP); step(SP);
    tests++;
    if (match !== 1'b1) begin
      fails++; $display("FAIL param change keeps match: got %b exp 1", match);
    end
  endtask

  task automatic test_mid_reset();
    flagged_string = 136'("www.google.com");
    strlen = 5'd14;
    flush_clear();
    for (int j = 0; j < 5; j++) step(g_seq[0][j]);
    step("www.");
    step("goog");
    n_rst = 1'b0;
    #2;
    tests++;
    if (data_out !== 32'h0) begin
      fails++; $display("FAIL midreset data_out: got %h exp 00000000", data_out);
    end
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL midreset match: got %b exp 0", match);
    end
    #1;
    n_rst = 1'b1;
    step("le.c");
    step("om  ");
    tests++;
    if (data_out !== 32'h0) begin
      fails++; $display("FAIL midreset flushed data_out: got %h exp 00000000", data_out);
    end
    repeat (3) step(SP);
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL midreset cut string match: got %b exp 0", match);
    end
  endtask

  task automatic test_case();
    logic exp_m;
`ifdef STRING_COMPARATOR_NOCASE_EN
    exp_m = 1'b1;
`else
    exp_m = 1'b0;
`endif
    flagged_string = 136'("abc");
    strlen = 5'd3;
    flush_clear();
    step(" ABC");
    step(SP);
    tests++;
    if (match !== exp_m) begin
      fails++; $display("FAIL case letters match: got %b exp %b", match, exp_m);
    end
    flagged_string = 136'("a@c");
    flush_clear();
    step(" A`c");
    step(SP);
    tests++;
    if (match !== 1'b0) begin
      fails++; $display("FAIL case non-letter match: got %b exp 0", match);
    end
  endtask

  initial begin
    g_seq = '{'{"www.", "goog", "le.c", "om  ", "    "},
              '{" www", ".goo", "gle.", "com ", "    "},
              '{"  ww", "w.go", "ogle", ".com", "    "},
              '{"   w", "ww.g", "oogl", "e.co", "m   "}};
    clear = 1'b0;
    data_in = 32'h0;
    strlen = 5'd0;
    flagged_string = '0;
    test_reset();
    test_google();
    test_abc();
    test_len17();
    test_no_match();
    test_bounds();
    test_clear();
    test_mid_reset();
    test_case();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/string_comparator.md
STRING_COMPARATOR -- requirements
Module: string_comparator

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and n_rst.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-004 Port clear, input, 1 bit: synchronous clear of the match flag.
REQ-005 Port flagged_string, input, packed [0:16][7:0]: target string, right-justified; the last character is at index 16 and the first at index 17-strlen.
REQ-006 Port strlen, input, 5 bits: target length in bytes; valid range 1..17.
REQ-007 Port data_in, input, 32 bits: one stream word per cycle; the first byte in stream order is bits 31:24.
REQ-008 Port data_out, output, 32 bits: data_in delayed through the pipeline.
REQ-009 Port match, output, 1 bit: sticky flag indicating that the target string was seen in the stream.

Function
REQ-010 data_in SHALL be captured on every rising clk edge; there is no valid or handshake signal.
REQ-011 The block SHALL hold a 6-stage word pipeline. A word captured at edge k SHALL appear on data_out after edge k+5, and data_out is the stage-6 register.
REQ-012 The search window SHALL be the 20 bytes held in stages 1..5, in stream order, with stage 1 being the newest word.
REQ-013 Each cycle, the block SHALL evaluate 4 candidate end positions: bytes 0..3 of the stage-1 word.
REQ-014 A candidate SHALL hit when the strlen window bytes ending at that position equal flagged_string[17-strlen..16] in order.
REQ-015 Matches SHALL be found at any byte alignment and SHALL span word boundaries.
REQ-016 If any candidate hits, match SHALL be set at the next edge, so that a last target byte captured at edge k gives match=1 after edge k+1.
REQ-017 match SHALL stay at 1 until clear or reset; new hits while match=1 have no further effect.
REQ-018 clear=1 at an edge SHALL force match to 0 at that edge, and clear SHALL take priority over a simultaneous hit.
REQ-019 clear SHALL NOT flush the data pipeline or the window.
REQ-020 strlen=0 or strlen>17 SHALL never produce a hit.
REQ-021 Comparison SHALL be a full 8-bit byte compare, with no special treatment of 0x00 or space, so an all-zero string matches an all-zero stream.
REQ-022 Changing flagged_string or strlen SHALL take effect on the next evaluation and SHALL NOT clear match.

Reset
REQ-023 While n_rst=0, all pipeline stages, data_out and match SHALL be 0 immediately, independent of clk.
REQ-024 Reset in mid-stream SHALL discard all buffered bytes; a string cut by reset SHALL NOT match.

Configuration
REQ-025 Macro STRING_COMPARATOR_NOCASE_EN, when defined, SHALL make the compare case-insensitive for ASCII letters A-Z/a-z (bit 5 ignored for those bytes only).
REQ-026 Without STRING_COMPARATOR_NOCASE_EN, the compare SHALL be an exact byte compare.

Structure
REQ-027 Package string_comparator_pkg SHALL hold the constants MAX_STRLEN=17, WORD_BYTES=4, WIN_WORDS=5 and PIPE_STAGES=6, plus the byte and flagged-string typedefs.
REQ-028 One sub-module, strcmp_window_match, SHALL be instantiated once.
REQ-029 strcmp_window_match SHALL be purely combinational: inputs are the 20-byte window, flagged_string and strlen; the output is the hit flag for the 4 end positions.

Verification
REQ-030 Reset: assert n_rst=0 -> data_out=0 and match=0 immediately.
REQ-031 strlen=14, target "www.google.com", stream "www." "goog" "le.c" "om  " "    " -> data_out replays the same words 5 cycles later, and match=1 when "    " is on data_out; repeat at offsets 1, 2 and 3 (" www"..., "  ww"..., "   w"...) -> match=1 each time after clear.
REQ-032 strlen=3, target "abc", "abc"/" abc" placed in each of 5 word positions among "    " words -> match=1 in every case.
REQ-033 strlen=17, target "www.linkedin.com/", stream "www." "link" "edin" ".com" "/   " -> match=1; target all-ones with a stream of all-ones -> match=1; target all-zeros with a stream of all-zeros -> match=1.
REQ-034 Target "www.google.com", stream "www." "goog" "book" ".com" -> match stays 0 and data_out still replays the words.
REQ-035 Clear pulse while match=1 -> match=0 next cycle; clear coincident with a hit -> match=0.
